// File: rtl/dac_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dac_seq_pkg
// Description : Shared types and helpers for the DAC cell sequencer.
//               - dac_state_t : sequencer state encoding (OFF/SETTLE/RUN/RAMP)
//               - midscale()  : offset-binary midscale code for a code width
//               - nu_cells()  : unary cell count for a unary segment width
// Revision    : 1.0 - initial release
// ============================================================================
package dac_seq_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_RAMP   = 2'd3
    } dac_state_t;

    // Offset-binary zero: only the code MSB set.
    function automatic int unsigned midscale(input int unsigned nbits);
        return 32'd1 << (nbits - 32'd1);
    endfunction

    // A thermometer segment of nmsb bits needs 2^nmsb-1 equal cells.
    function automatic int unsigned nu_cells(input int unsigned nmsb);
        return (32'd1 << nmsb) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_dwa_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dac_dwa_decoder
// Description : Unary-segment decoder. Converts the MSB part m of the current
//               code into a cell-select vector and computes the next DWA
//               pointer. Purely combinational; both inputs come from
//               registers in the parent.
//   m      : number of unary cells to switch on (0..NU)
//   p      : rotation pointer, first cell used (0..NU-1)
//   sw_u   : cell select vector (bit i = cell i steered to vout)
//   p_next : (p + m) mod NU
// Revision    : 1.0 - initial release
// ============================================================================
module dac_dwa_decoder #(
    parameter int NMSB   = 4,
    parameter int NU     = 15,
    parameter bit DWA_EN = 1'b1
) (
    input  logic [NMSB-1:0] m,
    input  logic [NMSB-1:0] p,
    output logic [NU-1:0]   sw_u,
    output logic [NMSB-1:0] p_next
);

    localparam logic [NMSB:0] c_NU_X = (NMSB+1)'(NU);

    logic [NU-1:0] w_therm;
    logic [NMSB:0] w_sum;

    // Plain thermometer: cells 0..m-1 on.
    for (genvar i = 0; i < NU; i++) begin : g_therm
        assign w_therm[i] = (m > NMSB'(i));
    end

    if (DWA_EN) begin : g_dwa
        logic [NMSB-1:0] w_rsh;
        // Rotate the thermometer left by p inside an NU-wide ring. The ring is
        // NU (not a power of two) wide, so the wrap is built from two shifts;
        // with p=0 the right shift is NU places and contributes nothing.
        assign w_rsh = NMSB'(NU) - p;
        assign sw_u  = (w_therm << p) | (w_therm >> w_rsh);
    end else begin : g_fixed
        assign sw_u = w_therm;
    end

    // p < NU and m <= NU, so one conditional subtraction is a full modulo.
    // m = NU leaves the pointer where it was.
    assign w_sum  = {1'b0, p} + {1'b0, m};
    assign p_next = (w_sum >= c_NU_X) ? NMSB'(w_sum - c_NU_X) : NMSB'(w_sum);

endmodule

`default_nettype wire

// File: rtl/dac_cell_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dac_cell_sequencer
// Description : Digital front end of the segmented current-steering DAC.
//               Accepts offset-binary samples on a valid/ready handshake,
//               splits each code into unary MSB cells (optionally rotated by
//               data-weighted averaging) and binary LSB cells, and sequences
//               settle / mute / ramp-down so the load never steps abruptly.
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : level, request DAC active
//   mute           : level, glide to midscale and hold there
//   din/din_valid  : sample input; din_ready high only in RUN while en=1
//   sw_u / sw_ub   : unary cell steer, vout / voutb side
//   sw_b / sw_bb   : binary cell steer, vout / voutb side
//   state          : OFF=0, SETTLE=1, RUN=2, RAMP=3
//   underrun       : RUN, not muted, no valid sample this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module dac_cell_sequencer
    import dac_seq_pkg::*;
#(
    parameter int NBITS         = 8,
    parameter int NMSB          = 4,
    parameter int NLSB          = NBITS - NMSB,
    parameter int SETTLE_CYCLES = 64,
    parameter bit DWA_EN        = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mute,
    input  logic [NBITS-1:0]          din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic [nu_cells(NMSB)-1:0] sw_u,
    output logic [nu_cells(NMSB)-1:0] sw_ub,
    output logic [NLSB-1:0]           sw_b,
    output logic [NLSB-1:0]           sw_bb,
    output logic [1:0]                state,
    output logic                      underrun
);

    localparam int               c_NU          = int'(nu_cells(NMSB));
    localparam int               c_CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [NBITS-1:0] c_MID         = NBITS'(midscale(NBITS));
    localparam logic [NBITS-1:0] c_ONE         = NBITS'(1);
    localparam logic [c_CW-1:0]  c_SETTLE_LOAD = c_CW'(SETTLE_CYCLES - 1);

    dac_state_t       r_state;
    dac_state_t       w_state_nxt;
    logic [NBITS-1:0] r_code;
    logic [NBITS-1:0] w_code_nxt;
    logic [NBITS-1:0] w_code_step;
    logic [NMSB-1:0]  r_ptr;
    logic [NMSB-1:0]  w_ptr_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [NMSB-1:0]  w_msb;
    logic [NLSB-1:0]  w_lsb;
    logic [c_NU-1:0]  w_cells;
    logic             w_accept;

    assign w_msb    = r_code[NBITS-1:NLSB];
    assign w_lsb    = r_code[NLSB-1:0];
    assign w_accept = din_valid && din_ready;
    assign state    = r_state;

    dac_dwa_decoder #(
        .NMSB   (NMSB),
        .NU     (c_NU),
        .DWA_EN (DWA_EN)
    ) u_dwa (
        .m      (w_msb),
        .p      (r_ptr),
        .sw_u   (w_cells),
        .p_next (w_ptr_nxt)
    );

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_OFF: begin
                if (en) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!en)              w_state_nxt = ST_OFF;
                else if (r_cnt == '0) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!en) w_state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                // en is deliberately ignored here: the ramp always completes.
                if (r_code == c_MID) w_state_nxt = ST_OFF;
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        din_ready = 1'b0;
        underrun  = 1'b0;
        sw_u      = '0;
        sw_ub     = '0;
        sw_b      = '0;
        sw_bb     = '0;
        // Ready drops combinationally with en so a sample offered on the same
        // cycle en falls is never taken.
        if (r_state == ST_RUN && en) begin
            din_ready = 1'b1;
            underrun  = !mute && !din_valid;
        end
        // In OFF both halves of every switching pair are open.
        if (r_state != ST_OFF) begin
            sw_u  = w_cells;
            sw_ub = ~w_cells;
            sw_b  = w_lsb;
            sw_bb = ~w_lsb;
        end
    end

    // ---------------------------------------------------------------- code datapath
    // One-LSB glide toward midscale, used by mute and ramp-down.
    always_comb begin
        w_code_step = r_code;
        if (r_code > c_MID) begin
            w_code_step = r_code - c_ONE;
        end else if (r_code < c_MID) begin
            w_code_step = r_code + c_ONE;
        end
    end

    always_comb begin
        w_code_nxt = r_code;
        unique case (r_state)
            ST_OFF, ST_SETTLE: begin
                w_code_nxt = c_MID;
            end
            ST_RUN: begin
                // The cycle en falls already takes the first ramp step, so
                // RAMP is entered one LSB closer to midscale. Muted samples
                // are accepted and discarded.
                if (!en || mute) begin
                    w_code_nxt = w_code_step;
                end else if (w_accept) begin
                    w_code_nxt = din;
                end
            end
            ST_RAMP: begin
                w_code_nxt = w_code_step;
            end
            default: w_code_nxt = c_MID;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= c_MID;
            r_ptr  <= '0;
            r_cnt  <= '0;
        end else begin
            r_code <= w_code_nxt;
            // The pointer advances by the cells driven this cycle, so every
            // cell carries the same average load over time.
            if (r_state != ST_OFF) begin
                r_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_OFF && en) begin
                r_cnt <= c_SETTLE_LOAD;
            end else if (r_state == ST_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - c_CW'(1);
            end
        end
    end

endmodule

`default_nettype wire
